// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_pkg
//  Brief    : Shared op encodings, default latencies and special-case result
//             constants for the multiply/divide unit.
//  Revision : 1.0  initial release
// ============================================================================
package mdu_pkg;

  // MDUsel encodings driven by the decoder
  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MADD  = 4'd7;
  localparam logic [3:0] MDU_MADDU = 4'd8;
  localparam logic [3:0] MDU_MSUB  = 4'd9;
  localparam logic [3:0] MDU_MSUBU = 4'd10;

  // Default busy-cycle counts
  localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
  localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

  // Divide-by-zero quotient; the remainder returns the dividend unchanged
  localparam logic [31:0] MDU_DIVZ_QUOT = 32'hFFFF_FFFF;

  // Signed overflow case: most-negative / -1
  localparam logic [31:0] MDU_OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [31:0] MDU_OVF_DIVISOR  = 32'hFFFF_FFFF;

  // Pending HI/LO pair held while an operation is in flight
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_hilo_t;

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_div_core.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_div_core
//  Brief    : Combinational signed/unsigned 32-bit divider. Quotient truncates
//             toward zero, remainder takes the sign of the dividend. Handles
//             the zero-divisor and most-negative/-1 cases explicitly.
//  Revision : 1.0  initial release
// ============================================================================
module mdu_div_core
  import mdu_pkg::*;
(
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        signed_i,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] uquot;
  logic [31:0] urem;

  // Work on magnitudes so one unsigned divider serves both signednesses
  assign neg_a = signed_i & dividend_i[31];
  assign neg_b = signed_i & divisor_i[31];
  assign mag_a = neg_a ? (32'd0 - dividend_i) : dividend_i;
  assign mag_b = neg_b ? (32'd0 - divisor_i)  : divisor_i;
  assign uquot = mag_a / mag_b;
  assign urem  = mag_a % mag_b;

  // Restore signs, then override with the architecturally defined special cases
  always_comb begin
    quot_o = (neg_a ^ neg_b) ? (32'd0 - uquot) : uquot;
    rem_o  = neg_a ? (32'd0 - urem) : urem;
    if (divisor_i == 32'd0) begin
      quot_o = MDU_DIVZ_QUOT;
      rem_o  = dividend_i;
    end else if (signed_i && (dividend_i == MDU_OVF_DIVIDEND) &&
                 (divisor_i == MDU_OVF_DIVISOR)) begin
      quot_o = MDU_OVF_DIVIDEND;
      rem_o  = 32'd0;
    end
  end

endmodule : mdu_div_core
`default_nettype wire

// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_unit
//  Brief    : EX-stage multi-cycle multiply/divide unit owning HI/LO. The
//             result is computed at accept time and held in a pending pair;
//             a down-counter models the latency and HI/LO are written on the
//             edge that ends the last busy cycle.
//  Options  : MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU accumulate ops.
//  Revision : 1.0  initial release
// ============================================================================
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUsel,
  input  logic        start,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [4:0] C_MULT_LAT = 5'(MULT_CYCLES);
  localparam logic [4:0] C_DIV_LAT  = 5'(DIV_CYCLES);

  logic [4:0]  cnt_q,  cnt_d;
  logic [31:0] hi_q,   hi_d;
  logic [31:0] lo_q,   lo_d;
  mdu_hilo_t   pend_q, pend_d;

  logic        accept;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] div_quot;
  logic [31:0] div_rem;

  assign busy   = (cnt_q != 5'd0);
  assign accept = start & ~flush & ~busy;
  assign HI     = hi_q;
  assign LO     = lo_q;

  // Full 64-bit products; sign-extending to 64 bits yields the signed product mod 2^64
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  mdu_div_core u_div_core (
    .dividend_i (A),
    .divisor_i  (B),
    .signed_i   (MDUsel == MDU_DIV),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

`ifdef MDU_MADD_EN
  logic [63:0] acc_now;
  assign acc_now = {hi_q, lo_q};
`endif

  // Next-state: count down while busy and retire on the last cycle, otherwise accept a new op
  always_comb begin
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    pend_d = pend_q;
    if (busy) begin
      cnt_d = cnt_q - 5'd1;
      if (cnt_q == 5'd1) begin
        hi_d = pend_q.hi;
        lo_d = pend_q.lo;
      end
    end else if (accept) begin
      case (MDUsel)
        MDU_MULT: begin
          pend_d = prod_s;
          cnt_d  = C_MULT_LAT;
        end
        MDU_MULTU: begin
          pend_d = prod_u;
          cnt_d  = C_MULT_LAT;
        end
        MDU_DIV, MDU_DIVU: begin
          pend_d = {div_rem, div_quot};
          cnt_d  = C_DIV_LAT;
        end
        MDU_MTHI: hi_d = A;
        MDU_MTLO: lo_d = A;
`ifdef MDU_MADD_EN
        MDU_MADD: begin
          pend_d = acc_now + prod_s;
          cnt_d  = C_MULT_LAT;
        end
        MDU_MADDU: begin
          pend_d = acc_now + prod_u;
          cnt_d  = C_MULT_LAT;
        end
        MDU_MSUB: begin
          pend_d = acc_now - prod_s;
          cnt_d  = C_MULT_LAT;
        end
        MDU_MSUBU: begin
          pend_d = acc_now - prod_u;
          cnt_d  = C_MULT_LAT;
        end
`endif
        default: ;
      endcase
    end
  end

  // State registers; reset abandons any in-flight op and clears HI/LO at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= 5'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      pend_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      pend_q <= pend_d;
    end
  end

endmodule : mdu_unit
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdu_unit
//  Brief    : Scoreboard bench for mdu_unit. The driver issues ops and pushes
//             the reference HI/LO and busy length; a negedge monitor pops and
//             compares whenever busy falls. Zero-latency ops are checked by
//             the driver one cycle after issue.
//  Options  : MDU_MADD_EN enables the accumulate reference and directed test.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mdu_unit;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MDUsel;
  logic        start;
  logic        flush;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  mdu_unit #(
    .MULT_CYCLES (MULT_LAT),
    .DIV_CYCLES  (DIV_LAT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .MDUsel (MDUsel),
    .start  (start),
    .flush  (flush),
    .busy   (busy),
    .HI     (HI),
    .LO     (LO)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] hi_m  = 32'd0;
  logic [31:0] lo_m  = 32'd0;
  bit          skip_fall = 1'b0;
  bit          prev_busy = 1'b0;
  int          run_len   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural effect of one accepted op, written from the arithmetic rules
  function automatic int ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sbv;
    logic [63:0] p;
    int          lat;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    lat = 0;
    case (op)
      4'd1: begin p = 64'(sa * sbv); {hi_m, lo_m} = p; lat = MULT_LAT; end
      4'd2: begin p = {32'd0, a} * {32'd0, b}; {hi_m, lo_m} = p; lat = MULT_LAT; end
      4'd3: begin
        if (b == 32'd0) begin lo_m = 32'hFFFF_FFFF; hi_m = a; end
        else begin lo_m = 32'(sa / sbv); hi_m = 32'(sa % sbv); end
        lat = DIV_LAT;
      end
      4'd4: begin
        if (b == 32'd0) begin lo_m = 32'hFFFF_FFFF; hi_m = a; end
        else begin lo_m = a / b; hi_m = a % b; end
        lat = DIV_LAT;
      end
      4'd5: hi_m = a;
      4'd6: lo_m = a;
`ifdef MDU_MADD_EN
      4'd7:  begin {hi_m, lo_m} = {hi_m, lo_m} + 64'(sa * sbv); lat = MULT_LAT; end
      4'd8:  begin {hi_m, lo_m} = {hi_m, lo_m} + {32'd0, a} * {32'd0, b}; lat = MULT_LAT; end
      4'd9:  begin {hi_m, lo_m} = {hi_m, lo_m} - 64'(sa * sbv); lat = MULT_LAT; end
      4'd10: begin {hi_m, lo_m} = {hi_m, lo_m} - {32'd0, a} * {32'd0, b}; lat = MULT_LAT; end
`endif
      default: ;
    endcase
    return lat;
  endfunction

  // Monitor: a busy falling edge presents a result; compare against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (busy) run_len++;
    if (prev_busy && !busy) begin
      if (skip_fall) begin
        skip_fall = 1'b0;
      end else if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual=busy_fell required=no_op_in_flight");
      end else begin
        e = sb_q.pop_front();
        chk("result_hi", HI, e.hi);
        chk("result_lo", LO, e.lo);
        chk("busy_len", 32'(run_len), 32'(e.lat));
      end
      run_len = 0;
    end
    prev_busy = busy;
  end

  task automatic wait_idle();
    int n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout actual=still_pending required=done_within_60_cycles");
      sb_q.delete();
    end
  endtask

  // Drive one op for a single cycle, update the model and schedule the check
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit fl);
    int lat;
    @(negedge clk);
    MDUsel = op;
    A      = a;
    B      = b;
    start  = 1'b1;
    flush  = fl;
    @(posedge clk);
    #1;
    start  = 1'b0;
    flush  = 1'b0;
    MDUsel = 4'd0;
    A      = $urandom;
    B      = $urandom;
    lat    = fl ? 0 : ref_op(op, a, b);
    if (lat > 0) begin
      sb_q.push_back('{hi: hi_m, lo: lo_m, lat: lat});
    end else begin
      @(negedge clk);
      chk("imm_busy", {31'd0, busy}, 32'd0);
      chk("imm_hi", HI, hi_m);
      chk("imm_lo", LO, lo_m);
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit fl);
    issue(op, a, b, fl);
    wait_idle();
  endtask

  initial begin
    logic [31:0] sav_hi, sav_lo;
    logic [3:0]  op;
    logic [31:0] ra, rb;
    bit          rf;

    reset  = 1'b1;
    A      = 32'd0;
    B      = 32'd0;
    MDUsel = 4'd0;
    start  = 1'b0;
    flush  = 1'b0;
    #3;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed arithmetic cases with literal expectations
    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);
    run_op(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("multu_hi", HI, 32'h0000_0002);
    chk("multu_lo", LO, 32'hFFFF_FFFA);
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);
    run_op(4'd4, 32'd7, 32'd0, 1'b0);
    chk("divu0_lo", LO, 32'hFFFF_FFFF);
    chk("divu0_hi", HI, 32'd7);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("divovf_lo", LO, 32'h8000_0000);
    chk("divovf_hi", HI, 32'd0);
    run_op(4'd5, 32'h0000_1234, 32'd0, 1'b0);
    chk("mthi_hi", HI, 32'h0000_1234);
    run_op(4'd6, 32'h0000_5678, 32'd0, 1'b0);
    chk("mtlo_lo", LO, 32'h0000_5678);

    // Flushed start is discarded
    sav_hi = HI;
    sav_lo = LO;
    run_op(4'd1, 32'd9, 32'd9, 1'b1);
    chk("flush_hi", HI, sav_hi);
    chk("flush_lo", LO, sav_lo);

    // Flush without start during an in-flight op does not cancel it
    issue(4'd4, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_idle();
    chk("flushbusy_lo", LO, 32'd14);
    chk("flushbusy_hi", HI, 32'd2);

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(1, 6)) : 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 17));
        3: rb = -32'($urandom_range(1, 17));
        default: ;
      endcase
      rf = ($urandom_range(0, 7) == 0);
      run_op(op, ra, rb, rf);
    end

`ifdef MDU_MADD_EN
    run_op(4'd5, 32'd0, 32'd0, 1'b0);
    run_op(4'd6, 32'd5, 32'd0, 1'b0);
    run_op(4'd7, 32'd2, 32'd3, 1'b0);
    chk("madd_lo", LO, 32'd11);
    chk("madd_hi", HI, 32'd0);
    run_op(4'd9, 32'd4, 32'd4, 1'b0);
    chk("msub_lo", LO, 32'hFFFF_FFFB);
    chk("msub_hi", HI, 32'hFFFF_FFFF);
`endif

    // Reset during cycle 4 of a DIV: immediate clear, no later write
    run_op(4'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
    run_op(4'd6, 32'hCAFE_F00D, 32'd0, 1'b0);
    issue(4'd3, 32'd1000, 32'd3, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    skip_fall = 1'b1;
    sb_q.delete();
    reset = 1'b1;
    #1;
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_hi", HI, 32'd0);
    chk("rstmid_lo", LO, 32'd0);
    #1;
    reset = 1'b0;
    hi_m  = 32'd0;
    lo_m  = 32'd0;
    repeat (15) @(negedge clk);
    chk("rstlate_busy", {31'd0, busy}, 32'd0);
    chk("rstlate_hi", HI, 32'd0);
    chk("rstlate_lo", LO, 32'd0);

    // Unit still operates after the abandoned op
    run_op(4'd2, 32'd6, 32'd7, 1'b0);
    chk("post_rst_lo", LO, 32'd42);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mdu_unit
`default_nettype wire

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, beside the ALU.
- Consumes the same forwarded A/B operands as the ALU.
- Owns the HI/LO architectural registers. HI/LO feed the EX result mux for mfhi/mflo, alongside ALU C.
- Drives busy to the hazard unit, which stalls ID for any MDU-class instruction while busy or start is high.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd-family when enabled); legal range 1..31.
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..31.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high; clears all state
- A  in  32  forwarded rs operand
- B  in  32  forwarded rt operand
- MDUsel  in  4  op code of the EX instruction (encodings in package)
- start  in  1  EX holds a valid MDU write-class instruction this cycle
- flush  in  1  exception/interrupt cancel of the EX instruction this cycle
- busy  out  1  operation in flight
- HI  out  32  current HI register
- LO  out  32  current LO register

Behaviour:
- Reset (async, active-high): HI=0, LO=0, busy=0, counter=0, pending results cleared. Effect is immediate, independent of clk.
- Op encodings:
  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO.
  - 7–10 reserved for the optional feature.
  - Any other value: no effect.
- Accept condition: start=1, flush=0, busy=0. Any start while busy=1 is ignored; the hazard unit guarantees this never happens.
- MULT/MULTU/DIV/DIVU on accept:
  - Compute the result from A/B, capture it into pending HI/LO, load counter with the op's latency.
  - busy=1 from the next cycle for exactly that many cycles.
  - HI/LO update on the edge that ends the last busy cycle, so new HI/LO and busy=0 are visible in the same cycle.
- MTHI/MTLO on accept: HI (resp. LO) ← A at the next edge; busy stays 0.
- Arithmetic:
  - MULT: signed 32×32→64, HI=[63:32], LO=[31:0]. MULTU: unsigned.
  - DIV: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Boundary results:
  - Divide by zero (both signednesses): LO=32'hFFFFFFFF, HI=A.
  - DIV 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0.
  - Neither case raises an exception.
- flush with start: the op is discarded; HI/LO and busy are unchanged.
- flush while busy with start=0: no effect. The in-flight op already left EX uncancelled and completes.
- Reset mid-operation: the op is abandoned, pending results are never written, busy drops at once.
- Outputs HI/LO are plain register outputs; no bypass of pending results.

Optional Feature:
- Macro: MDU_MADD_EN.
- With the macro: ops 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU are enabled.
  - Operation: {HI,LO} ← {HI,LO} ± A×B, signed/unsigned accordingly, 64-bit wrap.
  - Latency MULT_CYCLES.
  - {HI,LO} is sampled at accept time.
- Without the macro: codes 7–10 behave as NONE; no accumulate datapath is synthesised.

Decomposition:
- Shared package mdu_pkg:
  - MDUsel localparams (MDU_NONE … MDU_MSUBU).
  - Default latency constants.
  - Divide-by-zero result constants.
- One natural sub-module, mdu_div_core: combinational signed/unsigned quotient/remainder with the zero-divisor and overflow special cases.
- mdu_unit holds the counter, pending registers, HI/LO and the accept logic.

Test Plan:
- MULT A=32'hFFFFFFFE, B=3, start 1 cycle → busy=1 for 5 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA, busy=0.
- MULTU A=32'hFFFFFFFE, B=3 → HI=32'h00000002, LO=32'hFFFFFFFA after 5 busy cycles.
- DIV A=32'hFFFFFFF9 (-7), B=2 → 10 busy cycles, LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- DIVU A=7, B=0 → LO=32'hFFFFFFFF, HI=7. DIV A=32'h80000000, B=32'hFFFFFFFF → LO=32'h80000000, HI=0.
- MTHI A=32'h00001234 → HI=32'h00001234 next cycle, busy stays 0. MULT with start=flush=1 → busy stays 0, HI/LO unchanged.
- Reset pulse during cycle 4 of a DIV → busy=0, HI=LO=0 immediately; no later write. (MDU_MADD_EN build only) MADD after HI=0, LO=5 with A=2, B=3 → LO=11, HI=0.
